// File: rtl/seq_divider_pkg.sv
// Shared definitions for the iterative integer divider.
// div_state_t : controller states of seq_divider.
// DIV_WIDTH   : default operand width.
// DIV_LATENCY : cycles a normal request keeps ok low. The imul/idiv busy
//               logic and the scheduler use this value.
package seq_divider_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with RISC-V M-extension semantics
// (DIV/DIVU/REM/REMU). It produces one quotient bit per cycle and takes
// one request at a time.
//
// state    | meaning
// DIV_IDLE | ok=1, results valid; a start is accepted here
// DIV_CALC | one shift/trial-subtract step per cycle, counter counts down
// DIV_FIX  | sign correction or divide-by-zero result, then back to idle
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   start            request strobe, honoured only while ok=1
//   is_signed, A, B  operation mode, dividend and divisor, sampled with start
//   D, R             registered quotient and remainder of the last request
//   ok               1 = idle and results valid
//   err              1 = the last completed request divided by zero
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] a_orig_q, a_orig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             divzero_q, divzero_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign sign_a = is_signed & A[WIDTH-1];
    assign sign_b = is_signed & B[WIDTH-1];
    assign mag_a  = sign_a ? -A : A;
    assign mag_b  = sign_b ? -B : B;

    // The partial remainder never exceeds the divisor, so its top bit is
    // always zero before the shift; the extra bit only carries the borrow.
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_q};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        a_orig_d  = a_orig_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        divzero_d = divzero_q;
        d_d       = d_q;
        r_d       = r_q;
        ok_d      = ok_q;
        err_d     = err_q;

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    rem_d     = '0;
                    quo_d     = mag_a;
                    div_d     = mag_b;
                    a_orig_d  = A;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    cnt_d     = CNT_INIT;
                    err_d     = 1'b0;
                    ok_d      = 1'b0;
                    divzero_d = (B == '0);
                    state_d   = (B == '0) ? DIV_FIX : DIV_CALC;
                end
            end

            DIV_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DIV_FIX: begin
                if (divzero_q) begin
                    d_d   = '1;
                    r_d   = a_orig_q;
                    err_d = 1'b1;
                end else begin
                    d_d = neg_quo_q ? -quo_q : quo_q;
                    r_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                ok_d    = 1'b1;
                state_d = DIV_IDLE;
            end

            default: begin
                state_d = DIV_IDLE;
                ok_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            a_orig_q  <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divzero_q <= 1'b0;
            d_q       <= '0;
            r_q       <= '0;
            ok_q      <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            a_orig_q  <= a_orig_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            divzero_q <= divzero_d;
            d_q       <= d_d;
            r_q       <= r_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end

    assign D   = d_q;
    assign R   = r_q;
    assign ok  = ok_q;
    assign err = err_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] D;
    logic [31:0] R;
    logic        ok;
    logic        err;

    int checks = 0;
    int errors = 0;
    int busy;

    seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .D         (D),
        .R         (R),
        .ok        (ok),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge; returns at the negedge just after the accept edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        A         = a;
        B         = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedge samples with ok=0, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (ok !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout observed ok=%b expected ok=1", ok);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        A         = '0;
        B         = '0;
        #12;
        check("reset_ok",  {31'd0, ok},  32'd1);
        check("reset_D",   D,            32'd0);
        check("reset_R",   R,            32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Unsigned 100/7
        issue(1'b0, 32'd100, 32'd7);
        wait_done(busy);
        check("u100_7_busy", busy, 32'd33);
        check("u100_7_D", D, 32'd14);
        check("u100_7_R", R, 32'd2);
        check("u100_7_err", {31'd0, err}, 32'd0);

        // Signed -7/2
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(busy);
        check("s-7_2_D", D, 32'hFFFF_FFFD);
        check("s-7_2_R", R, 32'hFFFF_FFFF);

        // Signed 7/-2
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(busy);
        check("s7_-2_D", D, 32'hFFFF_FFFD);
        check("s7_-2_R", R, 32'd1);

        // Signed -7/-2
        issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        wait_done(busy);
        check("s-7_-2_D", D, 32'd3);
        check("s-7_-2_R", R, 32'hFFFF_FFFF);

        // Divide by zero, signed
        issue(1'b1, 32'h1234, 32'd0);
        wait_done(busy);
        check("dz_s_busy", busy, 32'd1);
        check("dz_s_D", D, 32'hFFFF_FFFF);
        check("dz_s_R", R, 32'h1234);
        check("dz_s_err", {31'd0, err}, 32'd1);

        // Divide by zero, unsigned
        issue(1'b0, 32'h1234, 32'd0);
        wait_done(busy);
        check("dz_u_busy", busy, 32'd1);
        check("dz_u_D", D, 32'hFFFF_FFFF);
        check("dz_u_R", R, 32'h1234);
        check("dz_u_err", {31'd0, err}, 32'd1);

        // Signed overflow
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(busy);
        check("ovf_s_D", D, 32'h8000_0000);
        check("ovf_s_R", R, 32'd0);
        check("ovf_s_err", {31'd0, err}, 32'd0);

        // Same operands unsigned
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(busy);
        check("ovf_u_D", D, 32'd0);
        check("ovf_u_R", R, 32'h8000_0000);

        // Start pulsed during a running request is ignored
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1;
        A     = 32'd5;
        B     = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done(busy);
        check("ign_busy_rest", busy, 32'd23);
        check("ign_D", D, 32'd14);
        check("ign_R", R, 32'd2);
        @(negedge clk);
        check("ign_no_relaunch", {31'd0, ok}, 32'd1);

        // Back-to-back: start held high across completion
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        A         = 32'd100;
        B         = 32'd7;
        @(negedge clk);
        A = 32'd9;
        B = 32'd3;
        wait_done(busy);
        check("b2b_first_busy", busy, 32'd33);
        check("b2b_first_D", D, 32'd14);
        @(negedge clk);
        check("b2b_second_accepted", {31'd0, ok}, 32'd0);
        start = 1'b0;
        wait_done(busy);
        check("b2b_second_busy", busy, 32'd33);
        check("b2b_second_D", D, 32'd3);
        check("b2b_second_R", R, 32'd0);

        // Reset mid-operation
        issue(1'b0, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ok", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        check("midrst_ok2", {31'd0, ok}, 32'd1);
        check("midrst_D", D, 32'd0);
        check("midrst_R", R, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(1'b0, 32'd9, 32'd3);
        wait_done(busy);
        check("post_rst_busy", busy, 32'd33);
        check("post_rst_D", D, 32'd3);
        check("post_rst_R", R, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
